// File: rtl/screens_pkg.sv
// Shared types and helpers for the sequenced screen multiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package screens_pkg;

    typedef enum logic [1:0] {OFF, BLANK, SHOW} screen_state_t;

    localparam logic [7:0] DEFAULT_BLANK_COLOR = 8'h00;

    // Width of an index/counter able to hold n distinct values, never below 1 bit.
    function automatic int idx_w(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/screen_prio_enc.sv
// Fixed-priority encoder: lowest set enable bit wins (index 0 highest priority).
// Latency: purely combinational.
// Backpressure: none.
//   screen_en    : per-screen enables from the game state machine
//   target       : index of the winning screen (0 when none set)
//   target_valid : at least one enable set
module screen_prio_enc
    import screens_pkg::*;
#(
    parameter int NUM_SCREENS = 3,
    parameter int IW          = idx_w(NUM_SCREENS)
) (
    input  logic [NUM_SCREENS-1:0] screen_en,
    output logic [IW-1:0]          target,
    output logic                   target_valid
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        target       = '0;
        target_valid = 1'b0;
        for (int i = NUM_SCREENS - 1; i >= 0; i--) begin
            if (screen_en[i]) begin
                target       = IW'(i);
                target_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/screens_mux_seq.sv
// Screen source mux with frame-counted blanking between screens and a minimum display hold.
// Latency: all outputs registered, one clk after the inputs that produce them.
// Backpressure: none; pixel stream flows every cycle, screen changes are deferred, never stalled.
//   clk, resetN          : clock, asynchronous active-low reset
//   startOfFrame         : one-cycle pulse per frame, paces blanking and hold counters
//   screen_en            : wanted screens; lowest set index wins
//   drawingRequest / RGB : per-screen bitmap request and packed colour
//   RGBOut / screenDrawingRequest : registered selected pixel
//   active_screen        : shown (SHOW) or pending (BLANK) screen index
//   active_valid / transition_busy : high in SHOW / BLANK respectively
module screens_mux_seq
    import screens_pkg::*;
#(
    parameter int               NUM_SCREENS     = 3,
    parameter int               RGB_W           = 8,
    parameter int               BLANK_FRAMES    = 2,
    parameter int               MIN_SHOW_FRAMES = 4,
    parameter logic [RGB_W-1:0] BLANK_COLOR     = RGB_W'(DEFAULT_BLANK_COLOR)
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           startOfFrame,
    input  logic [NUM_SCREENS-1:0]         screen_en,
    input  logic [NUM_SCREENS-1:0]         drawingRequest,
    input  logic [NUM_SCREENS*RGB_W-1:0]   RGB,
    output logic [RGB_W-1:0]               RGBOut,
    output logic                           screenDrawingRequest,
    output logic [idx_w(NUM_SCREENS)-1:0]  active_screen,
    output logic                           active_valid,
    output logic                           transition_busy
);

    localparam int IW = idx_w(NUM_SCREENS);
    localparam int BW = idx_w(BLANK_FRAMES + 1);
    localparam int SW = idx_w(MIN_SHOW_FRAMES + 1);
    localparam logic [BW-1:0] BLANK_LOAD = BW'(BLANK_FRAMES);
    localparam logic [SW-1:0] SHOW_MAX   = SW'(MIN_SHOW_FRAMES);
    // With no blanking frames a new screen is entered straight into SHOW.
    localparam bit DIRECT = (BLANK_FRAMES == 0);

    logic [IW-1:0]    target;
    logic             target_valid;
    logic [RGB_W-1:0] rgb_arr [NUM_SCREENS];
    screen_state_t    state;
    logic [BW-1:0]    blank_cnt;
    logic [SW-1:0]    show_cnt;
    logic             hold_done;

    screen_prio_enc #(
        .NUM_SCREENS (NUM_SCREENS),
        .IW          (IW)
    ) u_prio (
        .screen_en    (screen_en),
        .target       (target),
        .target_valid (target_valid)
    );

    for (genvar i = 0; i < NUM_SCREENS; i++) begin : g_rgb
        assign rgb_arr[i] = RGB[i*RGB_W +: RGB_W];
    end

    // show_cnt saturates at the hold length, so equality marks the hold as served.
    assign hold_done = (show_cnt == SHOW_MAX);

    // active_screen doubles as the pending index while blanking.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state                <= OFF;
            RGBOut               <= BLANK_COLOR;
            screenDrawingRequest <= 1'b0;
            active_screen        <= '0;
            active_valid         <= 1'b0;
            transition_busy      <= 1'b0;
            blank_cnt            <= '0;
            show_cnt             <= '0;
        end else begin
            // Pixel path follows the state held during this cycle.
            case (state)
                SHOW: begin
                    RGBOut               <= rgb_arr[active_screen];
                    screenDrawingRequest <= drawingRequest[active_screen];
                end
                BLANK: begin
                    RGBOut               <= BLANK_COLOR;
                    screenDrawingRequest <= 1'b1;
                end
                default: begin
                    RGBOut               <= BLANK_COLOR;
                    screenDrawingRequest <= 1'b0;
                end
            endcase

            case (state)
                OFF: begin
                    if (target_valid) begin
                        active_screen <= target;
                        blank_cnt     <= BLANK_LOAD;
                        show_cnt      <= '0;
                        if (DIRECT) begin
                            state        <= SHOW;
                            active_valid <= 1'b1;
                        end else begin
                            state           <= BLANK;
                            transition_busy <= 1'b1;
                        end
                    end
                end
                BLANK: begin
                    if (!target_valid) begin
                        state           <= OFF;
                        transition_busy <= 1'b0;
                    end else if (target != active_screen) begin
                        // Retarget restarts the full blank; a coincident frame pulse is dropped.
                        active_screen <= target;
                        blank_cnt     <= BLANK_LOAD;
                    end else if (startOfFrame) begin
                        blank_cnt <= blank_cnt - 1'b1;
                        if (blank_cnt == BW'(1)) begin
                            state           <= SHOW;
                            transition_busy <= 1'b0;
                            active_valid    <= 1'b1;
                            show_cnt        <= '0;
                        end
                    end
                end
                SHOW: begin
                    if (startOfFrame && !hold_done) begin
                        show_cnt <= show_cnt + 1'b1;
                    end
                    // Requests arriving during the hold are simply re-evaluated each cycle.
                    if (hold_done) begin
                        if (!target_valid) begin
                            state        <= OFF;
                            active_valid <= 1'b0;
                        end else if (target != active_screen) begin
                            active_screen <= target;
                            blank_cnt     <= BLANK_LOAD;
                            show_cnt      <= '0;
                            if (!DIRECT) begin
                                state           <= BLANK;
                                active_valid    <= 1'b0;
                                transition_busy <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state           <= OFF;
                    active_valid    <= 1'b0;
                    transition_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_screens_mux_seq.sv
module tb_screens_mux_seq;

    localparam int N  = 3;
    localparam int W  = 8;
    localparam int RW = N * W;
    localparam int BF = 2;
    localparam int MS = 4;
    localparam logic [W-1:0]  BC       = 8'h00;
    localparam logic [RW-1:0] PLAN_RGB = {8'h1C, 8'h5A, 8'hE0};

    logic          clk = 1'b0;
    logic          resetN = 1'b0;
    logic          startOfFrame = 1'b0;
    logic [N-1:0]  screen_en = '0;
    logic [N-1:0]  drawingRequest = '0;
    logic [RW-1:0] RGB = '0;
    logic [W-1:0]  RGBOut;
    logic          screenDrawingRequest;
    logic [1:0]    active_screen;
    logic          active_valid;
    logic          transition_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: 0 = off, 1 = blanking, 2 = showing.
    int         m_st, m_cur, m_left, m_shown;
    logic [W-1:0] m_rgb;
    logic       m_req;

    screens_mux_seq #(
        .NUM_SCREENS     (N),
        .RGB_W           (W),
        .BLANK_FRAMES    (BF),
        .MIN_SHOW_FRAMES (MS),
        .BLANK_COLOR     (BC)
    ) dut (
        .clk                  (clk),
        .resetN               (resetN),
        .startOfFrame         (startOfFrame),
        .screen_en            (screen_en),
        .drawingRequest       (drawingRequest),
        .RGB                  (RGB),
        .RGBOut               (RGBOut),
        .screenDrawingRequest (screenDrawingRequest),
        .active_screen        (active_screen),
        .active_valid         (active_valid),
        .transition_busy      (transition_busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_st = 0; m_cur = 0; m_left = 0; m_shown = 0; m_rgb = BC; m_req = 1'b0;
    endtask

    task automatic model_enter(input int t);
        m_cur = t; m_shown = 0; m_left = BF;
        m_st = (BF == 0) ? 2 : 1;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_edge();
        int tgt;
        tgt = -1;
        for (int i = N - 1; i >= 0; i--) if (screen_en[i]) tgt = i;
        if (m_st == 2) begin
            m_rgb = W'(RGB >> (m_cur * W));
            m_req = |(drawingRequest & (N'(1) << m_cur));
        end else begin
            m_rgb = BC;
            m_req = (m_st == 1);
        end
        case (m_st)
            0: if (tgt >= 0) model_enter(tgt);
            1: begin
                if (tgt < 0) m_st = 0;
                else if (tgt != m_cur) begin m_cur = tgt; m_left = BF; end
                else if (startOfFrame) begin
                    m_left--;
                    if (m_left == 0) begin m_st = 2; m_shown = 0; end
                end
            end
            default: begin
                if (m_shown >= MS && tgt < 0) m_st = 0;
                else if (m_shown >= MS && tgt != m_cur) model_enter(tgt);
                else if (startOfFrame) m_shown++;
            end
        endcase
    endtask

    function automatic logic [12:0] obs();
        return {RGBOut, screenDrawingRequest, active_screen, active_valid, transition_busy};
    endfunction

    function automatic logic [12:0] exp_out();
        return {m_rgb, m_req, 2'(m_cur), m_st == 2, m_st == 1};
    endfunction

    // active_screen is only meaningful outside OFF.
    function automatic logic [12:0] msk();
        return (m_st == 0) ? 13'h1FF3 : 13'h1FFF;
    endfunction

    task automatic step(input logic sof, input logic [N-1:0] en, input logic [N-1:0] dr);
        startOfFrame   = sof;
        screen_en      = en;
        drawingRequest = dr;
        @(posedge clk);
        if (resetN) model_edge();
        #1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        RGB = PLAN_RGB;
        screen_en = 3'b001;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        n_checks++;
        if (obs() !== 13'h0000) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs(), 13'h0000);
        end
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_first_show();
        int blank_sofs = 0;
        for (int k = 0; k < 20; k++) begin
            logic s;
            s = (k % 6 == 5);
            if (transition_busy && s) blank_sofs++;
            step(s, 3'b001, 3'($urandom));
            n_checks++;
            if ((obs() & msk()) !== (exp_out() & msk())) begin
                n_fail++;
                $display("FAIL first_show k=%0d: got %h want %h", k, obs() & msk(), exp_out() & msk());
            end
        end
        n_checks++;
        if (blank_sofs !== 2) begin n_fail++; $display("FAIL first_blank_frames: got %0d want 2", blank_sofs); end
        n_checks++;
        if ({RGBOut, active_screen, active_valid} !== {8'hE0, 2'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL first_show_final: got %h/%0d/%b want e0/0/1", RGBOut, active_screen, active_valid);
        end
    endtask

    task automatic test_hold_switch();
        int held_sofs = 0;
        int blank_sofs = 0;
        for (int k = 0; k < 80; k++) begin
            logic s;
            s = (k % 6 == 5);
            if (s && active_valid && active_screen == 2'd0) held_sofs++;
            if (s && transition_busy) blank_sofs++;
            step(s, 3'b100, 3'($urandom));
            n_checks++;
            if ((obs() & msk()) !== (exp_out() & msk())) begin
                n_fail++;
                $display("FAIL hold_switch k=%0d: got %h want %h", k, obs() & msk(), exp_out() & msk());
            end
        end
        n_checks++;
        if (held_sofs !== 3) begin n_fail++; $display("FAIL hold_frames: got %0d want 3", held_sofs); end
        n_checks++;
        if (blank_sofs !== 2) begin n_fail++; $display("FAIL switch_blank_frames: got %0d want 2", blank_sofs); end
        n_checks++;
        if ({RGBOut, active_screen} !== {8'h1C, 2'd2}) begin
            n_fail++;
            $display("FAIL screen2_shown: got %h/%0d want 1c/2", RGBOut, active_screen);
        end
    endtask

    task automatic test_priority();
        for (int k = 0; k < 40; k++) begin
            step(k % 6 == 5, 3'b110, 3'($urandom));
            n_checks++;
            if ((obs() & msk()) !== (exp_out() & msk())) begin
                n_fail++;
                $display("FAIL priority k=%0d: got %h want %h", k, obs() & msk(), exp_out() & msk());
            end
        end
        n_checks++;
        if ({active_screen, active_valid} !== {2'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL priority_winner: got %0d/%b want 1/1", active_screen, active_valid);
        end
        step(1'b0, 3'b110, 3'b101);
        n_checks++;
        if (screenDrawingRequest !== 1'b0) begin n_fail++; $display("FAIL req_low: got %b want 0", screenDrawingRequest); end
        step(1'b0, 3'b110, 3'b010);
        n_checks++;
        if ({screenDrawingRequest, RGBOut} !== {1'b1, 8'h5A}) begin
            n_fail++;
            $display("FAIL req_high: got %b/%h want 1/5a", screenDrawingRequest, RGBOut);
        end
    endtask

    task automatic test_off();
        for (int k = 0; k < 33; k++) begin
            step(k % 6 == 5 || k >= 30 ? 1'b0 : 1'b0, k < 30 ? 3'b110 : 3'b000, 3'($urandom));
            if (k < 30 && k % 6 == 5) begin end
            n_checks++;
            if ((obs() & msk()) !== (exp_out() & msk())) begin
                n_fail++;
                $display("FAIL off k=%0d: got %h want %h", k, obs() & msk(), exp_out() & msk());
            end
        end
        n_checks++;
        if ({screenDrawingRequest, active_valid, transition_busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL off_state: got req=%b valid=%b busy=%b want 0/0/0",
                     screenDrawingRequest, active_valid, transition_busy);
        end
    endtask

    task automatic test_blank_retarget();
        int sofs = 0;
        step(1'b0, 3'b010, 3'($urandom));
        step(1'b1, 3'b010, 3'($urandom));
        step(1'b0, 3'b010, 3'($urandom));
        step(1'b1, 3'b100, 3'($urandom));
        n_checks++;
        if ({active_screen, transition_busy} !== {2'd2, 1'b1}) begin
            n_fail++;
            $display("FAIL retarget_pending: got %0d/%b want 2/1", active_screen, transition_busy);
        end
        for (int k = 0; k < 60 && !active_valid; k++) begin
            logic s;
            s = (k % 4 == 3);
            if (s) sofs++;
            step(s, 3'b100, 3'($urandom));
            n_checks++;
            if ((obs() & msk()) !== (exp_out() & msk())) begin
                n_fail++;
                $display("FAIL retarget k=%0d: got %h want %h", k, obs() & msk(), exp_out() & msk());
            end
        end
        n_checks++;
        if (!active_valid || sofs !== 2) begin
            n_fail++;
            $display("FAIL retarget_frames: got %0d frames valid=%b want 2 frames valid=1", sofs, active_valid);
        end
    endtask

    task automatic test_async_reset();
        int sofs = 0;
        for (int k = 0; k < 200 && !transition_busy; k++) begin
            step(k % 4 == 3, 3'b010, 3'($urandom));
            n_checks++;
            if ((obs() & msk()) !== (exp_out() & msk())) begin
                n_fail++;
                $display("FAIL to_blank k=%0d: got %h want %h", k, obs() & msk(), exp_out() & msk());
            end
        end
        step(1'b1, 3'b010, 3'($urandom));
        n_checks++;
        if (transition_busy !== 1'b1) begin n_fail++; $display("FAIL mid_blank: got busy=%b want 1", transition_busy); end
        #2;
        resetN = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 13'h0000) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", obs(), 13'h0000);
        end
        model_reset();
        @(negedge clk);
        resetN = 1'b1;
        for (int k = 0; k < 100 && !active_valid; k++) begin
            logic s;
            s = (k % 4 == 3);
            if (s) sofs++;
            step(s, 3'b010, 3'($urandom));
            n_checks++;
            if ((obs() & msk()) !== (exp_out() & msk())) begin
                n_fail++;
                $display("FAIL after_reset k=%0d: got %h want %h", k, obs() & msk(), exp_out() & msk());
            end
        end
        n_checks++;
        if (!active_valid || active_screen !== 2'd1 || sofs !== 2) begin
            n_fail++;
            $display("FAIL restart_frames: got %0d frames screen=%0d want 2 frames screen=1", sofs, active_screen);
        end
    endtask

    task automatic test_random();
        logic [N-1:0] en;
        en = 3'b001;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 15) == 0) en = 3'($urandom);
            RGB = RW'($urandom);
            step($urandom_range(0, 4) == 0, en, 3'($urandom));
            n_checks++;
            if ((obs() & msk()) !== (exp_out() & msk())) begin
                n_fail++;
                $display("FAIL random k=%0d: got %h want %h", k, obs() & msk(), exp_out() & msk());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_show();
        test_hold_switch();
        test_priority();
        test_off();
        test_blank_retarget();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
